// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master shared by NREQ on-chip requesters.
// Runs SETUP/ACCESS phases, bounds pready waits with a timeout, returns per-requester responses.
module apb_req_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                   pclk,
   input  logic                   preset_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [ADDR_W-1:0]      paddr,
   output logic [DATA_W-1:0]      pwdata,
   input  logic [DATA_W-1:0]      prdata,
   input  logic                   pready,
   input  logic                   pslverr
);
   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant, done, expired;
   logic              psel_d, penable_d, pwrite_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d;
   logic [NREQ-1:0]   rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic              rsp_err_d;

   logic [ADDR_W-1:0] addr_arr  [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
   end

   // First valid requester after 'last'; the descending scan lets the nearest one win.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] pick;
      int unsigned      idx;
      pick = last;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (32'(last) + 32'(k)) % NREQ;
         if (valid[IDX_W'(idx)]) pick = IDX_W'(idx);
      end
      return pick;
   endfunction

   // Next-state, grant and registered-output next values.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr;
      pwdata_d    = pwdata;
      pwrite_d    = pwrite;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      req_ready   = '0;

      grant_idx = rr_pick(req_valid, last_q);
      // A ready slave in the expiry cycle wins over the timeout.
      expired   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !pready;
      done      = (state_q == ACCESS) && (pready || expired);
      grant     = preset_n && (|req_valid) && ((state_q == IDLE) || done);

      case (state_q)
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (done) state_d = IDLE;
            else      cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         rsp_valid_d[owner_q] = 1'b1;
         rsp_err_d            = expired | pslverr;
         rsp_rdata_d          = (expired || pwrite) ? '0 : prdata;
      end

      if (grant) begin
         req_ready[grant_idx] = 1'b1;
         state_d  = SETUP;
         last_d   = grant_idx;
         owner_d  = grant_idx;
         paddr_d  = addr_arr[grant_idx];
         pwdata_d = wdata_arr[grant_idx];
         pwrite_d = req_write[grant_idx];
      end

      psel_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= IDLE;
         last_q    <= IDX_W'(NREQ - 1);
         owner_q   <= '0;
         cnt_q     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         psel      <= psel_d;
         penable   <= penable_d;
         pwrite    <= pwrite_d;
         paddr     <= paddr_d;
         pwdata    <= pwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

endmodule
